comb_circ_sched: RTL

//  Shares one combinational evaluator (X = A&B | ~B&C, gate delays #1 each) among NREQ requesters.

---
 rtl/comb_circ_sched.sv | 131 +++++++++++++
 1 files changed

// File: rtl/comb_circ_sched.sv
// Round-robin scheduler sharing one external combinational evaluator among NREQ requesters.
// Optional self-check of the evaluator result is enabled by defining COMB_CIRC_SCHED_CHECK_EN.
module comb_circ_sched #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] ops,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              result,
  output logic              busy,
  output logic              ea,
  output logic              eb,
  output logic              ec,
  input  logic              ex,
  output logic              err
);

  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CW         = $clog2(SETTLE_EFF + 1);
  localparam int LW         = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_reg;
  logic [LW-1:0]   last_reg;
  logic [CW-1:0]   cnt_reg;
  logic [NREQ-1:0] gnt_reg;
  logic [NREQ-1:0] done_reg;
  logic            result_reg;
  logic            busy_reg;
  logic            ea_reg;
  logic            eb_reg;
  logic            ec_reg;
  logic            err_reg;

  logic [2:0]      ops_arr [NREQ];
  logic            win_valid;
  logic [LW-1:0]   win_idx;
  logic [LW-1:0]   cand;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
      assign ops_arr[gi] = ops[3*gi +: 3];
    end
  endgenerate

  // Scan downward so the requester closest after last_reg is written last and wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = LW'((int'(last_reg) + k) % NREQ);
      if (req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef COMB_CIRC_SCHED_CHECK_EN
  logic exp_x;
  assign exp_x = (ea_reg & eb_reg) | (~eb_reg & ec_reg);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      last_reg   <= LW'(NREQ - 1);
      cnt_reg    <= '0;
      gnt_reg    <= '0;
      done_reg   <= '0;
      result_reg <= 1'b0;
      busy_reg   <= 1'b0;
      ea_reg     <= 1'b0;
      eb_reg     <= 1'b0;
      ec_reg     <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            gnt_reg                  <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            {ea_reg, eb_reg, ec_reg} <= ops_arr[win_idx];
            last_reg                 <= win_idx;
            cnt_reg                  <= CW'(SETTLE_EFF - 1);
            busy_reg                 <= 1'b1;
            state_reg                <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CW'(1);
          end else begin
            result_reg <= ex;
            done_reg   <= gnt_reg;
            gnt_reg    <= '0;
            state_reg  <= RESP;
`ifdef COMB_CIRC_SCHED_CHECK_EN
            if (ex != exp_x) err_reg <= 1'b1;
`endif
          end
        end
        RESP: begin
          done_reg  <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt    = gnt_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign busy   = busy_reg;
  assign ea     = ea_reg;
  assign eb     = eb_reg;
  assign ec     = ec_reg;
`ifdef COMB_CIRC_SCHED_CHECK_EN
  assign err    = err_reg;
`else
  assign err    = 1'b0;
`endif

endmodule
